imem_load_ctrl: RTL
===================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter PC_WIDTH_LENGTH, default 32, is the fetch PC width.
REQ-002 Parameter INST_WIDTH_LENGTH, default 32, is the instruction word width.
REQ-003 Parameter ADDR_WIDTH, default 18, is the IMEM word-address width; word address = PC[ADDR_WIDTH+1:2].
REQ-004 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port if_pc  input  PC_WIDTH_LENGTH: fetch PC from the pipeline.
REQ-007 Port if_req  input  1: fetch request valid.
REQ-008 Port ld_start  input  1: begin program load (sampled in IDLE only).
REQ-009 Port ld_words  input  ADDR_WIDTH: number of words to load, latched on accepted ld_start.
REQ-010 Port ld_valid  input  1 / ld_byte  input  8: byte stream, transferred when ld_valid & ld_ready.
REQ-011 Port ld_ready  output  1: controller accepts a byte this cycle.
REQ-012 Port mem_addr  output  ADDR_WIDTH: IMEM word address.
REQ-013 Port mem_wdata  output  INST_WIDTH_LENGTH / mem_we  output  1: IMEM write data and strobe.
REQ-014 Port if_stall  output  1: fetch must hold; IMEM port owned by loader.
REQ-015 Port if_misalign  output  1: fetch PC not word-aligned.
REQ-016 Port done  output  1: one-cycle pulse at load completion.

Function
REQ-017 States SHALL be IDLE, LOAD, DONE; encoding free.
REQ-018 IDLE: mem_addr = if_pc[ADDR_WIDTH+1:2] combinationally, mem_we=0, ld_ready=0, if_stall=0.
REQ-019 IDLE: if_misalign = if_req & (if_pc[1:0] != 0), combinational; 0 in all other states.
REQ-020 IDLE & ld_start & ld_words!=0 -> LOAD; latch ld_words, clear byte counter (2 bit), word counter (ADDR_WIDTH bit) and assembly register.
REQ-021 IDLE & ld_start & ld_words==0 -> DONE; no write issued.
REQ-022 ld_start outside IDLE SHALL be ignored.
REQ-023 LOAD: ld_ready=1, if_stall=1; each transferred byte placed little-endian: byte k of a word -> bits [8k+7:8k].
REQ-024 On transfer of byte 3, the assembled word and current word counter SHALL be registered to mem_wdata/mem_addr with mem_we=1 in the following cycle only (one-cycle pulse); byte counter wraps to 0, word counter increments.
REQ-025 Byte intake SHALL continue without bubbles during a mem_we cycle (assembly register separate from mem_wdata).
REQ-026 If byte 3 of word ld_words-1 transfers, next state SHALL be DONE; that final write's mem_we coincides with DONE.
REQ-027 DONE: lasts exactly one cycle, done=1, if_stall=1, ld_ready=0, then IDLE.
REQ-028 Outside write cycles in LOAD/DONE, mem_addr and mem_wdata SHALL hold their last registered values, mem_we=0.
REQ-029 ld_valid low in LOAD: state, counters and partial word held indefinitely.
REQ-030 Word counter never wraps: maximum ld_words is 2^ADDR_WIDTH-1.

Reset
REQ-031 rst high at a clock edge: state IDLE, counters 0, assembly register 0, mem_wdata 0, registered mem_addr 0, mem_we 0, done 0.
REQ-032 rst mid-LOAD SHALL discard any partial word and suppress any pending write; no mem_we after the reset edge.
REQ-033 rst dominates ld_start and byte transfers in the same cycle.

Verification
REQ-034 if_pc=0x0000_0104, if_req=1 in IDLE -> mem_addr=0x00041, if_misalign=0, if_stall=0; if_pc=0x106 -> if_misalign=1.
REQ-035 ld_start, ld_words=2, bytes 78 56 34 12 EF BE AD DE back-to-back -> mem_we pulses: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; done pulse coincides with second write; IDLE next cycle.
REQ-036 ld_words=0 with ld_start -> DONE one cycle, done=1, no mem_we, then IDLE.
REQ-037 ld_words=1, ld_valid deasserted 5 cycles after byte 1 -> state held, ld_ready=1, if_stall=1; write 0x... occurs only after byte 3.
REQ-038 rst asserted after 6 bytes of a 3-word load -> exactly one write observed (addr 0), IDLE next cycle, subsequent new load starts at addr 0.
REQ-039 ld_start pulsed during LOAD -> ignored; latched word count unchanged.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl_if
// Groups the fetch, program-load byte stream and IMEM write signals that are
// exchanged between the pipeline/loader side and the IMEM load controller.
//   master : drives fetch PC/request, load start/word count and byte stream;
//            observes ld_ready, IMEM address/data/strobe, stall, misalign, done
//   slave  : the controller view (inputs/outputs mirrored)
// -----------------------------------------------------------------------------
interface imem_load_ctrl_if #(
    parameter int PC_WIDTH_LENGTH   = 32,
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int ADDR_WIDTH        = 18
);
    logic [PC_WIDTH_LENGTH-1:0]   if_pc;
    logic                         if_req;
    logic                         ld_start;
    logic [ADDR_WIDTH-1:0]        ld_words;
    logic                         ld_valid;
    logic [7:0]                   ld_byte;
    logic                         ld_ready;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [INST_WIDTH_LENGTH-1:0] mem_wdata;
    logic                         mem_we;
    logic                         if_stall;
    logic                         if_misalign;
    logic                         done;

    modport master (
        output if_pc, if_req, ld_start, ld_words, ld_valid, ld_byte,
        input  ld_ready, mem_addr, mem_wdata, mem_we, if_stall, if_misalign, done
    );

    modport slave (
        input  if_pc, if_req, ld_start, ld_words, ld_valid, ld_byte,
        output ld_ready, mem_addr, mem_wdata, mem_we, if_stall, if_misalign, done
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Shares one IMEM port between instruction fetch and a byte-serial program
// loader. In IDLE the fetch PC addresses the IMEM directly; during a load the
// incoming bytes are assembled little-endian into words and written one word
// per completed group of four bytes, with fetch stalled until load completes.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_load_ctrl_if.slave (fetch PC/req, load control, byte stream,
//          IMEM addr/wdata/we, if_stall, if_misalign, done)
// -----------------------------------------------------------------------------
module imem_load_ctrl #(
    parameter int PC_WIDTH_LENGTH   = 32,
    parameter int INST_WIDTH_LENGTH = 32,
    parameter int ADDR_WIDTH        = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_load_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       next_state_s;
    logic [ADDR_WIDTH-1:0]        words_r;
    logic [ADDR_WIDTH-1:0]        word_cnt_r;
    logic [1:0]                   byte_cnt_r;
    logic [23:0]                  asm_r;      // bytes 0..2 of the word in flight
    logic [INST_WIDTH_LENGTH-1:0] wr_data_r;
    logic [ADDR_WIDTH-1:0]        wr_addr_r;
    logic                         we_r;

    logic                         xfer_s;
    logic                         last_word_s;
    logic [31:0]                  word_s;
    logic [ADDR_WIDTH-1:0]        mem_addr_s;
    logic                         ld_ready_s;
    logic                         if_stall_s;
    logic                         if_misalign_s;
    logic                         done_s;
    logic                         unused_pc_s;

    assign xfer_s      = (state_r == ST_LOAD) & bus.ld_valid;
    // Byte 3 completes the word; it never goes through asm_r.
    assign word_s      = {bus.ld_byte, asm_r};
    assign last_word_s = xfer_s & (byte_cnt_r == 2'd3) &
                         (word_cnt_r == (words_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1}));
    // Only PC bits [ADDR_WIDTH+1:0] address the IMEM.
    assign unused_pc_s = ^bus.if_pc[PC_WIDTH_LENGTH-1:ADDR_WIDTH+2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    if (bus.ld_words != {ADDR_WIDTH{1'b0}}) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (last_word_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Per-state outputs; IMEM address follows fetch PC only while idle
    always_comb begin
        mem_addr_s    = wr_addr_r;
        ld_ready_s    = 1'b0;
        if_stall_s    = 1'b0;
        if_misalign_s = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_addr_s    = bus.if_pc[ADDR_WIDTH+1:2];
                if_misalign_s = bus.if_req & (bus.if_pc[1:0] != 2'b00);
            end
            ST_LOAD: begin
                ld_ready_s = 1'b1;
                if_stall_s = 1'b1;
            end
            ST_DONE: begin
                done_s     = 1'b1;
                if_stall_s = 1'b1;
            end
            default: begin
                mem_addr_s = wr_addr_r;
            end
        endcase
    end

    // Load datapath: latch count, assemble bytes, register completed words
    always_ff @(posedge clk) begin
        if (rst) begin
            words_r    <= {ADDR_WIDTH{1'b0}};
            word_cnt_r <= {ADDR_WIDTH{1'b0}};
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
            wr_data_r  <= {INST_WIDTH_LENGTH{1'b0}};
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            we_r       <= 1'b0;
        end else begin
            we_r <= 1'b0;
            if ((state_r == ST_IDLE) && bus.ld_start) begin
                words_r    <= bus.ld_words;
                word_cnt_r <= {ADDR_WIDTH{1'b0}};
                byte_cnt_r <= 2'd0;
                asm_r      <= 24'd0;
            end else if (xfer_s) begin
                byte_cnt_r <= byte_cnt_r + 2'd1;
                case (byte_cnt_r)
                    2'd0: asm_r[7:0]   <= bus.ld_byte;
                    2'd1: asm_r[15:8]  <= bus.ld_byte;
                    2'd2: asm_r[23:16] <= bus.ld_byte;
                    default: begin
                        // Commit goes to separate registers so intake continues
                        // into asm_r during the write cycle.
                        wr_data_r  <= INST_WIDTH_LENGTH'(word_s);
                        wr_addr_r  <= word_cnt_r;
                        word_cnt_r <= word_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        we_r       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = wr_data_r;
    assign bus.mem_we      = we_r;
    assign bus.ld_ready    = ld_ready_s;
    assign bus.if_stall    = if_stall_s;
    assign bus.if_misalign = if_misalign_s;
    assign bus.done        = done_s;
endmodule
